// File: rtl/div32_pkg.sv
// Shared types and constants for the 32-bit iterative divider.
package div32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set; 0x80000000 wraps onto itself.
    function automatic logic [DIV_WIDTH-1:0] apply_sign(input logic [DIV_WIDTH-1:0] mag,
                                                         input logic                 neg);
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/div32_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, try the subtract, keep it only if it did not borrow.
module div_step
    import div32_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic [DIV_WIDTH-1:0] quo,
    input  logic [DIV_WIDTH-1:0] dmag,
    output logic [DIV_WIDTH-1:0] rem_next,
    output logic [DIV_WIDTH-1:0] quo_next,
    output logic                 qbit
);

    logic [DIV_WIDTH:0] shifted;
    logic [DIV_WIDTH:0] diff;

    always_comb begin
        shifted  = {rem, quo[DIV_WIDTH-1]};
        // rem < dmag keeps shifted below 2*dmag, so bit 32 of diff is the borrow
        diff     = shifted - {1'b0, dmag};
        qbit     = ~diff[DIV_WIDTH];
        rem_next = qbit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
        quo_next = {quo[DIV_WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/div32.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per clock.
// Operands are reduced to magnitudes at start; signs are reapplied on completion.
module div32
    import div32_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sign,
    input  logic                 flush,
    input  logic [DIV_WIDTH-1:0] A,
    input  logic [DIV_WIDTH-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [DIV_WIDTH-1:0] LO,
    output logic [DIV_WIDTH-1:0] HI
);

    state_t               state;
    state_t               state_next;
    logic [5:0]           cnt;
    logic [DIV_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] dmag;
    logic [DIV_WIDTH-1:0] a_lat;
    logic                 neg_q;
    logic                 neg_r;
    logic [DIV_WIDTH-1:0] rem_next;
    logic [DIV_WIDTH-1:0] quo_next;
    logic                 qbit;
    logic                 accept;
    logic                 last_iter;
    logic                 b_zero;
    logic                 finish;

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .dmag     (dmag),
        .rem_next (rem_next),
        .quo_next (quo_next),
        .qbit     (qbit)
    );

    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (cnt == 6'(DIV_ITERS - 1));
    assign b_zero    = (dmag == '0);
    assign finish    = (state == BUSY) && !flush && (b_zero || last_iter);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !flush) state_next = BUSY;
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (b_zero || last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Working registers are only meaningful inside BUSY, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat <= A;
            dmag  <= apply_sign(B, sign & B[DIV_WIDTH-1]);
            quo   <= apply_sign(A, sign & A[DIV_WIDTH-1]);
            rem   <= '0;
            neg_q <= sign & (A[DIV_WIDTH-1] ^ B[DIV_WIDTH-1]);
            neg_r <= sign & A[DIV_WIDTH-1];
        end else if (state == BUSY) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

    // Visible results change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            LO       <= '0;
            HI       <= '0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 6'd1;
            end
            if (finish) begin
                if (b_zero) begin
                    LO       <= '1;
                    HI       <= a_lat;
                    div_zero <= 1'b1;
                end else begin
                    LO       <= apply_sign(quo_next, neg_q);
                    HI       <= apply_sign(rem_next, neg_r);
                    div_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_div32.sv
// Directed bench for div32: expected results are queued when a divide is
// launched and compared against the outputs when done is observed.
module tb_div32;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] lo;
    logic [31:0] hi;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div32 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sign     (sign),
        .flush    (flush),
        .A        (a),
        .B        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .LO       (lo),
        .HI       (hi)
    );

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t m;
        if (y == 32'd0) begin
            m.lo = 32'hFFFF_FFFF;
            m.hi = x;
            m.dz = 1'b1;
            m.lat = 1;
        end else begin
            m.dz = 1'b0;
            m.lat = 32;
            if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                m.lo = 32'h8000_0000;
                m.hi = 32'd0;
            end else if (s) begin
                m.lo = 32'($signed(x) / $signed(y));
                m.hi = 32'($signed(x) % $signed(y));
            end else begin
                m.lo = x / y;
                m.hi = x % y;
            end
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one divide; optionally pulse a competing start at offset intrude_k.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                           input int intrude_k);
        exp_t e;
        int   k;
        sb.push_back(model(x, y, s));
        a = x; b = y; sign = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sign = ~s;
        check("busy_after_start", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 100) begin
            start = (k == intrude_k);
            if (k == intrude_k) begin
                a = 32'd50; b = 32'd5;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check("done_latency", 32'(k), 32'(e.lat));
        check("done_seen", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("div_zero", 32'(div_zero), 32'(e.dz));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
        check("lo_hold", lo, e.lo);
        check("hi_hold", hi, e.hi);
    endtask

    initial begin
        int k;
        int saw_done;
        reset = 1'b0; start = 1'b0; sign = 1'b0; flush = 1'b0; a = '0; b = '0;
        #2;
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_div(32'd5, 32'd0, 1'b1, -1);
        run_div(32'd5, 32'd0, 1'b0, -1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, -1);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, -1);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            run_div($urandom, $urandom_range(1, 32'hFFFF), i[0], -1);
        end
        run_div(32'd100, 32'd7, 1'b0, -1);

        // Flush at iteration 10: back to IDLE, no done, prior result held.
        a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            saw_done |= int'(done);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_lo", lo, 32'd14);
        check("flush_hi", hi, 32'd2);
        repeat (40) begin
            @(negedge clk);
            saw_done |= int'(done);
        end
        check("flush_no_done", 32'(saw_done), 32'd0);
        run_div(32'd9, 32'd3, 1'b0, -1);

        // Start together with flush in IDLE must not launch.
        a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("startflush_busy", 32'(busy), 32'd0);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            saw_done |= int'(done);
        end
        check("startflush_no_done", 32'(saw_done), 32'd0);
        check("startflush_lo", lo, 32'd3);

        // Start pulse while busy is ignored; result stays that of 100/7.
        run_div(32'd100, 32'd7, 1'b0, 5);

        // Reset mid-divide at iteration 20 abandons it.
        a = 32'd100; b = 32'd7; sign = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 20; k++) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_lo", lo, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_dz", 32'(div_zero), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            saw_done |= int'(done);
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        run_div(32'd100, 32'd7, 1'b0, -1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- sign  input  1  1 = signed (div), 0 = unsigned (divu); captured with start.
- flush  input  1  synchronous squash of an in-flight divide.
- A  input  32  dividend; captured with start.
- B  input  32  divisor; captured with start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; results are valid in that cycle.
- div_zero  output  1  the completed divide had B == 0; valid with done.
- LO  output  32  quotient.
- HI  output  32  remainder.

Function
REQ-002 The block SHALL implement a state machine with three states:
- IDLE to BUSY on start.
- BUSY to DONE after iteration 32.
- BUSY to DONE directly when B == 0.
- DONE to IDLE unconditionally.
REQ-003 When start is high at edge N in IDLE, the block SHALL latch A, B and sign, clear the iteration counter and enter BUSY at N.
REQ-004 The block SHALL perform one restoring shift-subtract iteration per BUSY edge (33-bit subtract of the divisor magnitude from the partial remainder), so that iteration 32 occurs at edge N+32.
REQ-005 For a nonzero divisor, done SHALL be high exactly during the cycle between edges N+32 and N+33, and busy SHALL be high from edge N to edge N+33.
REQ-006 In signed mode the block SHALL divide magnitudes, then set the quotient sign = A[31] XOR B[31] and the remainder sign = A[31], so that HI has the sign of the dividend.
REQ-007 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0 (two's-complement wrap), with no overflow flag.
REQ-008 When B == 0, the block SHALL enter DONE at edge N+1 with LO = 0xFFFFFFFF, HI = A and div_zero = 1, regardless of sign.
REQ-009 LO, HI and div_zero SHALL hold their values after done until the next accepted start.
REQ-010 A start while busy is high (BUSY or DONE) SHALL be ignored and not queued.
REQ-011 A flush in BUSY or DONE SHALL return the block to IDLE on the next edge, with done not asserted and LO/HI unchanged from their pre-start values.
REQ-012 If start and flush are both high in IDLE, flush SHALL win and no divide starts.
REQ-013 The divider SHALL NOT update LO/HI before done; the partial quotient and remainder SHALL live in internal registers only.

Reset
REQ-014 While reset is low, the block SHALL asynchronously force state to IDLE and the counter, LO, HI, div_zero, done and busy all to 0.
REQ-015 A reset asserted mid-operation SHALL abandon the divide with no done pulse, and the first start after reset deasserts SHALL behave exactly as REQ-003.

Structure
REQ-016 A shared package SHALL hold:
- the IDLE/BUSY/DONE state typedef;
- the constants DIV_WIDTH = 32 and DIV_ITERS = 32.
REQ-017 A combinational sub-module div_step SHALL compute one iteration: partial remainder, partial quotient, divisor magnitude in; next remainder and quotient bit out.
REQ-018 The ripple ALU SHALL NOT be reused for the iteration subtract.

Verification
REQ-019 Unsigned 100 / 7, start at edge 0: done in cycle 32-33, LO = 14, HI = 2, div_zero = 0.
REQ-020 Signed -7 / 2 (0xFFFFFFF9 / 0x2): LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; unsigned 0xFFFFFFF9 / 2: LO = 0x7FFFFFFC, HI = 1.
REQ-021 Divide 5 / 0, either sign: done at edge 1, LO = 0xFFFFFFFF, HI = 5, div_zero = 1.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-023 Flush at iteration 10 of 100 / 7:
- IDLE next edge, no done, LO/HI retain the prior result;
- a new start of 9 / 3 must then give LO = 3, HI = 0.
REQ-024 Reset low at iteration 20 and a start pulse at iteration 5: reset clears all outputs to 0, and the start pulse leaves the in-flight result unchanged.
